// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct constants and shared types for the ID branch unit
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } br_state_e;

  function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/id_operand_fwd.sv
// rtl/id_operand_fwd.sv - selects one branch operand (RF or MEM forward) and its stall need
module id_operand_fwd
  import mips_pkg::*;
(
  input  logic [4:0]  src_reg,
  input  logic [31:0] rf_data,
  input  logic        RegWrite_EX,
  input  logic        MemRead_EX,
  input  logic [4:0]  Write_Register_EX,
  input  logic        RegWrite_MEM,
  input  logic        MemRead_MEM,
  input  logic [4:0]  Write_Register_MEM,
  input  logic [31:0] ALU_Result_MEM,
  output logic [31:0] value,
  output logic [1:0]  need
);

  logic src_zero;
  logic ex_match;
  logic mem_match;

  assign src_zero  = (src_reg == REG_ZERO);
  assign ex_match  = !src_zero && (Write_Register_EX == src_reg);
  assign mem_match = !src_zero && (Write_Register_MEM == src_reg);

  always_comb begin
    value = rf_data;
    if (src_zero) begin
      value = 32'd0;
    end else if (RegWrite_MEM && !MemRead_MEM && mem_match) begin
      value = ALU_Result_MEM;
    end
  end

  // A load still in EX needs two cycles before its data reaches the write-through RF.
  always_comb begin
    need = 2'd0;
    if (ex_match && MemRead_EX) begin
      need = 2'd2;
    end else if (ex_match && RegWrite_EX) begin
      need = 2'd1;
    end else if (mem_match && MemRead_MEM) begin
      need = 2'd1;
    end
  end

endmodule

// File: rtl/id_branch_resolve.sv
// rtl/id_branch_resolve.sv - ID-stage BEQ/BNE/J/JR resolution with forwarding, hazard stall and stats
module id_branch_resolve
  import mips_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter bit JR_EN = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Valid_ID,
  input  logic [31:0]      Instruction_ID,
  input  logic [31:0]      PC_Plus_4_ID,
  input  logic [31:0]      Read_Data_1_ID,
  input  logic [31:0]      Read_Data_2_ID,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [4:0]       Write_Register_EX,
  input  logic             RegWrite_MEM,
  input  logic             MemRead_MEM,
  input  logic [4:0]       Write_Register_MEM,
  input  logic [31:0]      ALU_Result_MEM,
  output logic [31:0]      Branch_Dest_ID,
  output logic             PCSrc_ID,
  output logic             Stall_ID,
  output logic             Flush_IF,
  output logic [CNT_W-1:0] Branch_Count,
  output logic [CNT_W-1:0] Taken_Count
);

  br_state_e   state, next_state;
  logic [1:0]  stall_cnt, stall_cnt_next;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic        is_beq, is_bne, is_j, is_jr, is_cond;

  logic [31:0] rs_val, rt_val;
  logic [1:0]  need_rs, need_rt, need;
  logic [31:0] br_target, j_target;
  logic        stall_raw, resolve, taken;

  assign opcode = Instruction_ID[31:26];
  assign rs     = Instruction_ID[25:21];
  assign rt     = Instruction_ID[20:16];
  assign imm    = Instruction_ID[15:0];
  assign funct  = Instruction_ID[5:0];

  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_j    = (opcode == OP_J);
  assign is_jr   = JR_EN && (opcode == OP_RTYPE) && (funct == FN_JR);
  assign is_cond = is_beq || is_bne;

  id_operand_fwd u_fwd_rs (
    .src_reg            (rs),
    .rf_data            (Read_Data_1_ID),
    .RegWrite_EX        (RegWrite_EX),
    .MemRead_EX         (MemRead_EX),
    .Write_Register_EX  (Write_Register_EX),
    .RegWrite_MEM       (RegWrite_MEM),
    .MemRead_MEM        (MemRead_MEM),
    .Write_Register_MEM (Write_Register_MEM),
    .ALU_Result_MEM     (ALU_Result_MEM),
    .value              (rs_val),
    .need               (need_rs)
  );

  id_operand_fwd u_fwd_rt (
    .src_reg            (rt),
    .rf_data            (Read_Data_2_ID),
    .RegWrite_EX        (RegWrite_EX),
    .MemRead_EX         (MemRead_EX),
    .Write_Register_EX  (Write_Register_EX),
    .RegWrite_MEM       (RegWrite_MEM),
    .MemRead_MEM        (MemRead_MEM),
    .Write_Register_MEM (Write_Register_MEM),
    .ALU_Result_MEM     (ALU_Result_MEM),
    .value              (rt_val),
    .need               (need_rt)
  );

  assign br_target = PC_Plus_4_ID + {{14{imm[15]}}, imm, 2'b00};
  assign j_target  = {PC_Plus_4_ID[31:28], Instruction_ID[25:0], 2'b00};

  always_comb begin
    Branch_Dest_ID = br_target;
    if (is_j) begin
      Branch_Dest_ID = j_target;
    end else if (is_jr) begin
      Branch_Dest_ID = rs_val;
    end
  end

  // JR reads only rs; J has no register sources and never stalls.
  always_comb begin
    need = 2'd0;
    if ((state == ST_IDLE) && Valid_ID && (is_cond || is_jr)) begin
      need = max_need(need_rs, is_cond ? need_rt : 2'd0);
    end
  end

  always_comb begin
    next_state     = state;
    stall_cnt_next = stall_cnt;
    stall_raw      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (need != 2'd0) begin
          stall_raw      = 1'b1;
          stall_cnt_next = need - 2'd1;
          if ((need - 2'd1) != 2'd0) begin
            next_state = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        stall_raw = 1'b1;
        if (!Valid_ID || (stall_cnt <= 2'd1)) begin
          next_state     = ST_IDLE;
          stall_cnt_next = 2'd0;
        end else begin
          stall_cnt_next = stall_cnt - 2'd1;
        end
      end
      default: begin
        next_state     = ST_IDLE;
        stall_cnt_next = 2'd0;
      end
    endcase
  end

  assign resolve = !Reset && (state == ST_IDLE) && Valid_ID && (need == 2'd0);

  always_comb begin
    taken = 1'b0;
    if (resolve) begin
      taken = (is_beq && (rs_val == rt_val)) ||
              (is_bne && (rs_val != rt_val)) ||
              is_j || is_jr;
    end
  end

  assign PCSrc_ID = taken;
  assign Flush_IF = taken;
  assign Stall_ID = stall_raw && !Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= ST_IDLE;
      stall_cnt    <= 2'd0;
      Branch_Count <= '0;
      Taken_Count  <= '0;
    end else begin
      state     <= next_state;
      stall_cnt <= stall_cnt_next;
      if (resolve && is_cond) begin
        Branch_Count <= Branch_Count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (taken) begin
        Taken_Count <= Taken_Count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_id_branch_resolve.sv
// tb/tb_id_branch_resolve.sv - directed self-checking bench for id_branch_resolve
module tb_id_branch_resolve;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Valid_ID;
  logic [31:0] Instruction_ID;
  logic [31:0] PC_Plus_4_ID;
  logic [31:0] Read_Data_1_ID;
  logic [31:0] Read_Data_2_ID;
  logic        RegWrite_EX;
  logic        MemRead_EX;
  logic [4:0]  Write_Register_EX;
  logic        RegWrite_MEM;
  logic        MemRead_MEM;
  logic [4:0]  Write_Register_MEM;
  logic [31:0] ALU_Result_MEM;
  logic [31:0] Branch_Dest_ID;
  logic        PCSrc_ID;
  logic        Stall_ID;
  logic        Flush_IF;
  logic [31:0] Branch_Count;
  logic [31:0] Taken_Count;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  id_branch_resolve #(.CNT_W(32), .JR_EN(1'b1)) dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .Valid_ID           (Valid_ID),
    .Instruction_ID     (Instruction_ID),
    .PC_Plus_4_ID       (PC_Plus_4_ID),
    .Read_Data_1_ID     (Read_Data_1_ID),
    .Read_Data_2_ID     (Read_Data_2_ID),
    .RegWrite_EX        (RegWrite_EX),
    .MemRead_EX         (MemRead_EX),
    .Write_Register_EX  (Write_Register_EX),
    .RegWrite_MEM       (RegWrite_MEM),
    .MemRead_MEM        (MemRead_MEM),
    .Write_Register_MEM (Write_Register_MEM),
    .ALU_Result_MEM     (ALU_Result_MEM),
    .Branch_Dest_ID     (Branch_Dest_ID),
    .PCSrc_ID           (PCSrc_ID),
    .Stall_ID           (Stall_ID),
    .Flush_IF           (Flush_IF),
    .Branch_Count       (Branch_Count),
    .Taken_Count        (Taken_Count)
  );

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_haz();
    RegWrite_EX = 0; MemRead_EX = 0; Write_Register_EX = 0;
    RegWrite_MEM = 0; MemRead_MEM = 0; Write_Register_MEM = 0; ALU_Result_MEM = 0;
  endtask

  task automatic ctl(input string tag, input logic stall, input logic pcsrc);
    chk({tag, "_stall"}, {31'd0, Stall_ID}, {31'd0, stall});
    chk({tag, "_pcsrc"}, {31'd0, PCSrc_ID}, {31'd0, pcsrc});
    chk({tag, "_flush"}, {31'd0, Flush_IF}, {31'd0, pcsrc});
  endtask

  task automatic cnts(input string tag, input logic [31:0] br, input logic [31:0] tk);
    chk({tag, "_brcnt"}, Branch_Count, br);
    chk({tag, "_tkcnt"}, Taken_Count, tk);
  endtask

  initial begin
    Reset = 1; Valid_ID = 0; Instruction_ID = 0; PC_Plus_4_ID = 0;
    Read_Data_1_ID = 0; Read_Data_2_ID = 0;
    clear_haz();
    repeat (2) @(negedge Clk);
    #1;
    ctl("reset", 0, 0);
    cnts("reset", 0, 0);
    Reset = 0;

    // BEQ $1,$2,+3 equal operands
    @(negedge Clk);
    Valid_ID = 1; Instruction_ID = itype(6'h04, 5'd1, 5'd2, 16'd3); PC_Plus_4_ID = 32'h100;
    Read_Data_1_ID = 32'h55; Read_Data_2_ID = 32'h55;
    #1;
    chk("beq_dest", Branch_Dest_ID, 32'h0000010C);
    ctl("beq", 0, 1);

    // BNE equal operands: not taken
    @(negedge Clk);
    cnts("after_beq", 1, 1);
    Instruction_ID = itype(6'h05, 5'd1, 5'd2, 16'd3);
    #1;
    ctl("bne_eq", 0, 0);

    // BEQ $3,$4 with a load to $3 in EX: two stall cycles
    @(negedge Clk);
    cnts("after_bne", 2, 1);
    Instruction_ID = itype(6'h04, 5'd3, 5'd4, 16'd1); PC_Plus_4_ID = 32'h200;
    Read_Data_1_ID = 32'h7; Read_Data_2_ID = 32'h7;
    RegWrite_EX = 1; MemRead_EX = 1; Write_Register_EX = 5'd3;
    #1;
    ctl("ld_stall1", 1, 0);
    @(negedge Clk);
    clear_haz();
    RegWrite_MEM = 1; MemRead_MEM = 1; Write_Register_MEM = 5'd3;
    #1;
    ctl("ld_stall2", 1, 0);
    cnts("ld_stall2", 2, 1);
    @(negedge Clk);
    clear_haz();
    #1;
    ctl("ld_resolve", 0, 1);
    chk("ld_dest", Branch_Dest_ID, 32'h00000204);

    // Forwarded MEM ALU result makes operands equal
    @(negedge Clk);
    cnts("after_ld", 3, 2);
    Read_Data_1_ID = 32'h7; Read_Data_2_ID = 32'h99;
    RegWrite_MEM = 1; MemRead_MEM = 0; Write_Register_MEM = 5'd3; ALU_Result_MEM = 32'h99;
    #1;
    ctl("fwd_eq", 0, 1);

    // Forwarded value makes otherwise-equal operands differ
    @(negedge Clk);
    cnts("after_fwd_eq", 4, 3);
    Read_Data_1_ID = 32'h5; Read_Data_2_ID = 32'h5; ALU_Result_MEM = 32'h6;
    #1;
    ctl("fwd_ne", 0, 0);

    // J with an EX load hazard: no stall
    @(negedge Clk);
    cnts("after_fwd_ne", 5, 3);
    clear_haz();
    Instruction_ID = {6'h02, 26'h0000040}; PC_Plus_4_ID = 32'h40000000;
    RegWrite_EX = 1; MemRead_EX = 1; Write_Register_EX = 5'd5;
    #1;
    chk("j_dest", Branch_Dest_ID, 32'h40000100);
    ctl("j", 0, 1);

    // Negative offset wraps below zero
    @(negedge Clk);
    cnts("after_j", 5, 4);
    clear_haz();
    Instruction_ID = itype(6'h05, 5'd1, 5'd2, 16'hFFFF); PC_Plus_4_ID = 32'h0;
    Read_Data_1_ID = 32'h1; Read_Data_2_ID = 32'h2;
    #1;
    chk("neg_dest", Branch_Dest_ID, 32'hFFFFFFFC);
    ctl("neg", 0, 1);

    // JR $5
    @(negedge Clk);
    cnts("after_neg", 6, 5);
    Instruction_ID = {6'h00, 5'd5, 15'd0, 6'h08}; Read_Data_1_ID = 32'h1234;
    #1;
    chk("jr_dest", Branch_Dest_ID, 32'h00001234);
    ctl("jr", 0, 1);

    // BEQ $0,$0 with EX load to $0: reads zero, no stall
    @(negedge Clk);
    cnts("after_jr", 6, 6);
    Instruction_ID = itype(6'h04, 5'd0, 5'd0, 16'd2);
    Read_Data_1_ID = 32'h1; Read_Data_2_ID = 32'h2;
    RegWrite_EX = 1; MemRead_EX = 1; Write_Register_EX = 5'd0;
    #1;
    ctl("zero_reg", 0, 1);

    // Non-load EX hazard on rt: single stall cycle
    @(negedge Clk);
    cnts("after_zero", 7, 7);
    clear_haz();
    Instruction_ID = itype(6'h05, 5'd6, 5'd7, 16'd2);
    Read_Data_1_ID = 32'h3; Read_Data_2_ID = 32'h4;
    RegWrite_EX = 1; MemRead_EX = 0; Write_Register_EX = 5'd7;
    #1;
    ctl("alu_stall", 1, 0);
    @(negedge Clk);
    clear_haz();
    #1;
    ctl("alu_resolve", 0, 1);

    // Valid_ID drop during STALL: back to IDLE with no resolution
    @(negedge Clk);
    cnts("after_alu", 8, 8);
    Instruction_ID = itype(6'h04, 5'd3, 5'd4, 16'd1);
    Read_Data_1_ID = 32'h7; Read_Data_2_ID = 32'h7;
    RegWrite_EX = 1; MemRead_EX = 1; Write_Register_EX = 5'd3;
    #1;
    ctl("drop_stall", 1, 0);
    @(negedge Clk);
    clear_haz();
    Valid_ID = 0;
    #1;
    ctl("drop_in_stall", 1, 0);
    @(negedge Clk);
    #1;
    ctl("drop_bubble", 0, 0);
    @(negedge Clk);
    cnts("after_drop", 8, 8);

    // Reset asserted while in STALL
    Valid_ID = 1;
    RegWrite_EX = 1; MemRead_EX = 1; Write_Register_EX = 5'd3;
    #1;
    ctl("rst_pre", 1, 0);
    @(negedge Clk);
    Reset = 1;
    #1;
    ctl("rst_during", 0, 0);
    @(negedge Clk);
    cnts("rst_after", 0, 0);
    Reset = 0;
    clear_haz();
    #1;
    ctl("rst_idle", 0, 1);
    @(negedge Clk);
    cnts("rst_resolve", 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
